// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and idle line levels.
// Used by both the SPI slave and the SPI master.
package spi_pkg;

    localparam int   DATA_W_DEF = 8;

    localparam logic MISO_IDLE  = 1'b1;
    localparam logic CS_IDLE    = 1'b1;
    localparam logic SCLK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE  = 1'b1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input.
// The reset value is a parameter, so the output comes out of reset at the line's idle level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples its pre-edge inputs regardless of the order of the statements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by the system clock. It has a one-entry TX buffer, a
// registered miso, and it can run back-to-back frames while cs stays low.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);

    localparam int CNT_W   = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic cs_s, sclk_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(cs), .q_o(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
    );

    spi_state_e        state_q;
    logic              cs_q, sclk_q;
    logic [FLUSH_W-1:0] flush_q;
    logic              armed_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q, buf_q;
    logic              buf_full_q, miso_q, rx_valid_q, underrun_q;

    logic              cs_fall, cs_rise, sclk_rise, sclk_fall, reload_d;
    logic [DATA_W-1:0] tx_load_d, tx_shift_d, rx_shift_d;

    // A cs falling edge is only trusted once the synchronizer has flushed its reset value
    // and cs has been seen high. A frame cut short by reset therefore cannot resume.
    assign cs_fall   = armed_q & cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    assign tx_load_d  = buf_full_q ? buf_q : '1;
    assign tx_shift_d = {tx_sr_q[DATA_W-2:0], 1'b1};
    assign rx_shift_d = {rx_sr_q[DATA_W-2:0], mosi_s};
    assign reload_d   = (state_q == IDLE   && cs_fall) ||
                        (state_q == ACTIVE && !cs_rise && sclk_fall && cnt_q == '0);

    // NOTE: buf_q holds data only and is qualified by buf_full_q. It is therefore left out
    // of reset, so no reset logic is spent on a register that nothing reads while stale.
    always_ff @(posedge clk) begin
        if (tx_valid && !buf_full_q) begin
            buf_q <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_q       <= CS_IDLE;
            sclk_q     <= SCLK_IDLE;
            flush_q    <= '0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            tx_sr_q    <= '1;
            rx_sr_q    <= '1;
            rx_data_q  <= '0;
            buf_full_q <= 1'b0;
            miso_q     <= MISO_IDLE;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cs_q       <= cs_s;
            sclk_q     <= sclk_s;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            if (flush_q != FLUSH_W'(SYNC_STAGES)) begin
                flush_q <= flush_q + 1'b1;
            end else if (cs_s) begin
                armed_q <= 1'b1;
            end

            // Accept needs an empty buffer and a reload only drains a full one, so the
            // two never act on the buffer in the same cycle.
            if (tx_valid && !buf_full_q) begin
                buf_full_q <= 1'b1;
            end
            if (reload_d) begin
                tx_sr_q <= tx_load_d;
                miso_q  <= tx_load_d[DATA_W-1];
                if (buf_full_q) buf_full_q <= 1'b0;
                else            underrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        cnt_q   <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        miso_q  <= MISO_IDLE;
                        tx_sr_q <= '1;
                        rx_sr_q <= '1;
                    end else if (sclk_rise) begin
                        rx_sr_q <= rx_shift_d;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            rx_data_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (sclk_fall && cnt_q != '0) begin
                        tx_sr_q <= tx_shift_d;
                        miso_q  <= tx_sr_q[DATA_W-2];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master model, table-driven single frames,
// and hand-written sequences for back-to-back, abort, reset and idle-sclk cases.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W    = 8;
    localparam int SS   = 2;
    localparam int HALF = 4;   // sclk = clk/8

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cs = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso, tx_ready, rx_valid, tx_underrun;
    logic [W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: the master pushes the frame it sends, and the monitor pops it on rx_valid.
    logic [W-1:0] exp_q[$];
    int           rx_cnt = 0;
    int           ur_cnt = 0;
    logic [W-1:0] sb_exp;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(sb_exp));
            end
        end
        if (tx_underrun) ur_cnt++;
    end

    task automatic push_tx(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode 0: mosi is set while sclk is low, and miso is sampled just before the rising edge.
    task automatic xfer_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        mi = '1;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[W-1-i];
            repeat (HALF) @(negedge clk);
            mi[W-1-i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    typedef struct {
        logic         load;
        logic [W-1:0] tx;
        logic [W-1:0] mo;
        logic [W-1:0] exp_miso;
        int           exp_ur;
    } vec_t;

    vec_t         vecs[5];
    logic [W-1:0] m1, m2;
    int           rx0, ur0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Each frame ends with one more falling edge at the counter wrap. That edge reloads
        // from the buffer, so an empty buffer there adds one tx_underrun pulse.
        vecs[0] = '{1'b1, 8'h6A, 8'hA5, 8'h6A, 1};
        vecs[1] = '{1'b0, 8'h00, 8'h3C, 8'hFF, 2};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1};
        vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h81, 1};

        repeat (4) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].load) push_tx(vecs[v].tx);
            rx0 = rx_cnt;
            ur0 = ur_cnt;
            exp_q.push_back(vecs[v].mo);
            cs = 1'b0;
            xfer_bits(vecs[v].mo, W, m1);
            cs_high();
            check($sformatf("v%0d_miso", v), 32'(m1), 32'(vecs[v].exp_miso));
            check($sformatf("v%0d_rx_cnt", v), 32'(rx_cnt - rx0), 32'd1);
            check($sformatf("v%0d_underrun", v), 32'(ur_cnt - ur0), 32'(vecs[v].exp_ur));
            check($sformatf("v%0d_miso_idle", v), 32'(miso), 32'd1);
        end

        // Back-to-back frames under one cs; the second byte is loaded once the first is consumed.
        push_tx(8'h12);
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        fork
            begin
                @(negedge clk);
                cs = 1'b0;
                xfer_bits(8'hC3, W, m1);
                xfer_bits(8'h3C, W, m2);
                cs_high();
            end
            push_tx(8'h34);
        join
        check("b2b_miso0", 32'(m1), 32'h12);
        check("b2b_miso1", 32'(m2), 32'h34);
        check("b2b_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
        check("b2b_underrun", 32'(ur_cnt - ur0), 32'd1);

        // Abort after 5 bits. The next byte sits in the buffer and must survive the abort.
        push_tx(8'h93);
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        fork
            begin
                @(negedge clk);
                cs = 1'b0;
                xfer_bits(8'hF0, 5, m1);
            end
            push_tx(8'h3E);
        join
        @(negedge clk);
        cs = 1'b1;
        repeat (SS + 2) @(negedge clk);
        check("abort_miso_idle", 32'(miso), 32'd1);
        check("abort_partial_miso", 32'(m1[7:3]), 32'b10010);
        repeat (HALF) @(negedge clk);
        check("abort_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        check("abort_underrun", 32'(ur_cnt - ur0), 32'd0);
        check("abort_buf_kept", 32'(tx_ready), 32'd0);
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        exp_q.push_back(8'h96);
        cs = 1'b0;
        xfer_bits(8'h96, W, m1);
        cs_high();
        check("after_abort_miso", 32'(m1), 32'h3E);
        check("after_abort_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        check("after_abort_underrun", 32'(ur_cnt - ur0), 32'd1);

        // One-clk reset mid-frame. The rest of that frame must be ignored until cs toggles.
        push_tx(8'hAB);
        rx0 = rx_cnt;
        @(negedge clk);
        cs = 1'b0;
        xfer_bits(8'h55, 3, m1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_miso", 32'(miso), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_underrun", 32'(tx_underrun), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        xfer_bits(8'h00, 5, m1);
        check("midrst_tail_miso", 32'(m1[7:3]), 32'b11111);
        cs_high();
        check("midrst_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        push_tx(8'h55);
        ur0 = ur_cnt;
        exp_q.push_back(8'hAA);
        cs = 1'b0;
        xfer_bits(8'hAA, W, m1);
        cs_high();
        check("post_rst_miso", 32'(m1), 32'h55);
        check("post_rst_underrun", 32'(ur_cnt - ur0), 32'd1);

        // sclk toggling while deselected
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            check("idle_sclk_miso_lo", 32'(miso), 32'd1);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            check("idle_sclk_miso_hi", 32'(miso), 32'd1);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        check("idle_sclk_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        check("idle_sclk_underrun", 32'(ur_cnt - ur0), 32'd0);
        push_tx(8'h5E);
        exp_q.push_back(8'h0F);
        cs = 1'b0;
        xfer_bits(8'h0F, W, m1);
        cs_high();
        check("after_idle_miso", 32'(m1), 32'h5E);
        check("after_idle_rx_cnt", 32'(rx_cnt - rx0), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8: bits per SPI frame.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on cs, sclk and mosi.
REQ-003 Port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port cs  input  1: SPI chip select, active-low, asynchronous to clk.
REQ-006 Port sclk  input  1: SPI clock from master, CPOL=0, asynchronous to clk.
REQ-007 Port mosi  input  1: serial data from master, MSB first.
REQ-008 Port miso  output  1: serial data to master, MSB first; idles high.
REQ-009 Port tx_data  input  DATA_W: next byte to transmit.
REQ-010 Port tx_valid  input  1: tx_data offered.
REQ-011 Port tx_ready  output  1: one-entry TX buffer empty; transfer occurs when tx_valid&tx_ready.
REQ-012 Port rx_data  output  DATA_W: last complete received frame; holds until next frame.
REQ-013 Port rx_valid  output  1: one-clk pulse when rx_data updates; no backpressure.
REQ-014 Port tx_underrun  output  1: one-clk pulse when a frame starts with an empty TX buffer.

Function
REQ-015 cs, sclk and mosi each pass through SYNC_STAGES flops; cs and sclk edges come from comparing the last synchronized value with a registered copy.
REQ-016 Mode 0: mosi sampled on synchronized sclk rising edge; miso changes on synchronized sclk falling edge.
REQ-017 FSM states IDLE and ACTIVE; IDLE->ACTIVE on cs falling edge; ACTIVE->IDLE on cs rising edge.
REQ-018 On entry to ACTIVE: bit counter=0; TX shift register loads the buffer if full (buffer emptied), else all-ones plus tx_underrun pulse; miso = shift MSB in the same cycle.
REQ-019 Each sclk rising edge in ACTIVE: RX shift register shifts left with mosi in LSB; bit counter increments.
REQ-020 On the DATA_W-th rising edge: rx_data takes the assembled frame, rx_valid pulses next cycle, counter wraps to 0.
REQ-021 Each sclk falling edge in ACTIVE: TX shift register shifts left with 1 fill and miso takes the new MSB; if counter==0 (frame boundary), TX register reloads per REQ-018 rules instead, enabling back-to-back frames under one cs.
REQ-022 tx_ready = ~buffer_full; accept and consume never coincide.
REQ-023 cs rising mid-frame: partial RX frame discarded, no rx_valid, counter cleared, miso=1, partially sent TX frame lost; buffer contents retained.
REQ-024 sclk edges while in IDLE are ignored.
REQ-025 Supported sclk: high and low phases each >= SYNC_STAGES+2 clk periods; miso valid <= SYNC_STAGES+2 clk after sclk fall.
REQ-026 rx_data not read before next rx_valid is overwritten silently.

Reset
REQ-027 While rst_n=0 at a clk edge: FSM=IDLE, counter=0, miso=1, rx_data=0, rx_valid=0, tx_underrun=0, tx_ready=1 (buffer empty), TX/RX shift registers all-ones, synchronizers set to cs=1/sclk=0/mosi=1.
REQ-028 Reset asserted mid-frame aborts the frame with no rx_valid; frame resumes only on a fresh cs falling edge after release.

Structure
REQ-029 Shared spi_pkg holds the FSM state typedef, DATA_W default and idle-level constants (MISO_IDLE=1), shared with the SPI master.
REQ-030 One sub-module spi_sync (SYNC_STAGES-deep synchronizer with reset value parameter), instantiated three times.

Verification
REQ-031 Load 8'h6A, master sends 8'hA5 at sclk=clk/8 -> miso bits 0,1,1,0,1,0,1,0; rx_data=8'hA5; one rx_valid pulse.
REQ-032 No load before cs falls -> tx_underrun pulse, miso all ones for 8 bits, rx still captured.
REQ-033 Loads 8'h12 then 8'h34, 16 sclk under one cs, master sends 8'hC3,8'h3C -> miso 12,34; rx_valid twice with C3, 3C.
REQ-034 cs raised after 5 bits -> no rx_valid, miso=1 within SYNC_STAGES+2 clk, next frame correct from bit 7.
REQ-035 rst_n low mid-frame for one clk -> all outputs at REQ-027 values, tx_ready=1.
REQ-036 sclk toggling with cs high -> miso stays 1, no rx_valid, counter unchanged.
